// File: rtl/mms_pkg.sv
// Shared definitions for the streaming max/min tracker.
package mms_pkg;

  localparam int unsigned DATA_W_DEFAULT  = 8;
  localparam int unsigned MAX_LEN_DEFAULT = 16;

  // Selection mode encoding, shared with the parallel 4-number selector.
  localparam logic SEL_MAX = 1'b0;
  localparam logic SEL_MIN = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/mms_cmp_sel.sv
// One compare/select stage: decides whether a candidate displaces the current best.
module mms_cmp_sel
  import mms_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              mode_i,
  input  logic [DATA_W-1:0] best_i,
  input  logic [DATA_W-1:0] cand_i,
  output logic              replace_o,
  output logic [DATA_W-1:0] sel_o
);

  // Strict unsigned compare so ties keep the incumbent (earlier beat).
  always_comb begin
    replace_o = 1'b0;
    case (mode_i)
      SEL_MAX: replace_o = (cand_i > best_i);
      SEL_MIN: replace_o = (cand_i < best_i);
      default: replace_o = 1'b0;
    endcase
    sel_o = replace_o ? cand_i : best_i;
  end

endmodule

// File: rtl/mms_stream_tracker.sv
// Streaming max/min tracker: per frame reports the extreme value, its position and the frame length.
module mms_stream_tracker
  import mms_pkg::*;
#(
  parameter  int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter  int unsigned MAX_LEN = MAX_LEN_DEFAULT,
  localparam int unsigned IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              select,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [IDX_W-1:0]  out_index,
  output logic [CNT_W-1:0]  out_count
);

  state_e              state_q, state_d;
  logic                mode_q;
  logic [DATA_W-1:0]   best_q;
  logic [IDX_W-1:0]    idx_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_result_q;
  logic [IDX_W-1:0]    out_index_q;
  logic [CNT_W-1:0]    out_count_q;

  logic                accept_c;
  logic                first_c;
  logic                term_c;
  logic                load_out_c;
  logic                replace_c;
  logic [DATA_W-1:0]   cmp_sel_c;
  logic [DATA_W-1:0]   best_d;
  logic [IDX_W-1:0]    idx_d;
  logic [CNT_W-1:0]    cnt_d;

  assign accept_c = in_valid && in_ready_q;
  assign first_c  = (state_q == IDLE);

  mms_cmp_sel #(
    .DATA_W (DATA_W)
  ) u_cmp_sel (
    .mode_i    (mode_q),
    .best_i    (best_q),
    .cand_i    (in_data),
    .replace_o (replace_c),
    .sel_o     (cmp_sel_c)
  );

  // Running best/index/count after folding in the beat currently offered.
  always_comb begin
    best_d = best_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    if (first_c) begin
      best_d = in_data;
      idx_d  = '0;
      cnt_d  = CNT_W'(1);
    end else begin
      best_d = cmp_sel_c;
      idx_d  = replace_c ? IDX_W'(cnt_q) : idx_q;
      cnt_d  = cnt_q + CNT_W'(1);
    end
    term_c = in_last || (cnt_d == CNT_W'(MAX_LEN));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d = term_c ? OUT : ACC;
        end
      end
      ACC: begin
        if (accept_c && term_c) begin
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode; handshake flags are registered so they follow the next state.
  always_comb begin
    in_ready_d  = (state_d != OUT);
    out_valid_d = (state_d == OUT);
    load_out_c  = accept_c && term_c;
  end

  // Handshake flag registers; in_ready stays low while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Accumulator registers; mode is captured only on the first beat of a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= SEL_MAX;
      best_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
    end else if (accept_c) begin
      if (first_c) begin
        mode_q <= select;
      end
      best_q <= best_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
    end
  end

  // Result registers, loaded by the terminating beat and held until the next frame ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result_q <= '0;
      out_index_q  <= '0;
      out_count_q  <= '0;
    end else if (load_out_c) begin
      out_result_q <= best_d;
      out_index_q  <= idx_d;
      out_count_q  <= cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_index  = out_index_q;
  assign out_count  = out_count_q;

endmodule

// File: tb/tb_mms_stream_tracker.sv
// Bench for mms_stream_tracker: directed frames plus random traffic against a frame-level model.
module tb_mms_stream_tracker;

  localparam int unsigned DW = 8;
  localparam int unsigned ML = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          select;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic [3:0]    out_index;
  logic [4:0]    out_count;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int unsigned res;
    int unsigned idx;
    int unsigned cnt;
  } res_t;

  res_t        exp_q[$];
  res_t        got_q[$];
  int unsigned beats[$];
  logic        frame_sel;

  mms_stream_tracker #(
    .DATA_W  (DW),
    .MAX_LEN (ML)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .select     (select),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_index  (out_index),
    .out_count  (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Frame model: collect the frame's beats, then scan for the first extreme value.
  function automatic void model_beat(input int unsigned d, input logic l, input logic s);
    res_t r;
    if (beats.size() == 0) frame_sel = s;
    beats.push_back(d);
    if (l || beats.size() == ML) begin
      r.res = beats[0];
      r.idx = 0;
      for (int i = 1; i < beats.size(); i++) begin
        if (frame_sel ? (beats[i] < r.res) : (beats[i] > r.res)) begin
          r.res = beats[i];
          r.idx = i;
        end
      end
      r.cnt = beats.size();
      exp_q.push_back(r);
      beats.delete();
    end
  endfunction

  // One cycle: drive at the falling edge, check registered outputs, update the model.
  task automatic step(input logic v, input int unsigned d, input logic l, input logic s,
                      input logic r, output logic acc);
    res_t g;
    @(negedge clk);
    in_valid  = v;
    in_data   = DW'(d);
    in_last   = l;
    select    = s;
    out_ready = r;
    check("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    acc = v && in_ready;
    if (out_valid && exp_q.size() != 0) begin
      check("out_result", 32'(out_result), exp_q[0].res);
      check("out_index", 32'(out_index), exp_q[0].idx);
      check("out_count", 32'(out_count), exp_q[0].cnt);
      if (r) begin
        g.res = out_result;
        g.idx = out_index;
        g.cnt = out_count;
        got_q.push_back(g);
        void'(exp_q.pop_front());
      end
    end
    if (acc) model_beat(d, l, s);
  endtask

  task automatic send_beat(input int unsigned d, input logic l, input logic s, input logic r,
                           output int tries);
    logic acc;
    tries = 0;
    do begin
      step(1'b1, d, l, s, r, acc);
      tries++;
    end while (!acc && tries < 50);
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      step(1'b0, 0, 1'b0, 1'b0, 1'b1, acc);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_got(input string tag, input int k, input int unsigned res,
                           input int unsigned idx, input int unsigned cnt);
    check({tag, "_have"}, 32'(got_q.size() > k), 32'd1);
    if (got_q.size() > k) begin
      check({tag, "_res"}, got_q[k].res, res);
      check({tag, "_idx"}, got_q[k].idx, idx);
      check({tag, "_cnt"}, got_q[k].cnt, cnt);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_result", 32'(out_result), 32'd0);
    check("rst_out_index", 32'(out_index), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    exp_q.delete();
    beats.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int   t;
    logic acc;
    logic lp;
    rst_n     = 1'b0;
    select    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    frame_sel = 1'b0;

    do_reset();

    // Max frame
    got_q.delete();
    send_beat(3, 0, 0, 1, t);
    send_beat(200, 0, 0, 1, t);
    send_beat(17, 0, 0, 1, t);
    send_beat(200, 1, 0, 1, t);
    drain();
    check_got("max", 0, 200, 1, 4);

    // Min frame with tie
    got_q.delete();
    send_beat(9, 0, 1, 1, t);
    send_beat(4, 0, 1, 1, t);
    send_beat(4, 0, 1, 1, t);
    send_beat(250, 1, 1, 1, t);
    drain();
    check_got("min_tie", 0, 4, 1, 4);

    // Length cap splits 20 beats into 16 + 4
    got_q.delete();
    for (int i = 0; i < 20; i++) send_beat(i, i == 19, 0, 1, t);
    drain();
    check_got("cap1", 0, 15, 15, 16);
    check_got("cap2", 1, 19, 3, 4);

    // Backpressure with a single-beat frame
    got_q.delete();
    send_beat(42, 1, 0, 0, t);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 99, 1'b1, 1'b0, 1'b0, acc);
      check("bp_hold_no_accept", 32'(acc), 32'd0);
    end
    step(1'b1, 99, 1'b1, 1'b0, 1'b1, acc);
    check("bp_consume_no_accept", 32'(acc), 32'd0);
    send_beat(99, 1, 0, 1, t);
    check("bp_next_first_try", 32'(t), 32'd1);
    drain();
    check_got("bp1", 0, 42, 0, 1);
    check_got("bp2", 1, 99, 0, 1);

    // Select toggled mid-frame is ignored
    got_q.delete();
    send_beat(50, 0, 1, 1, t);
    send_beat(10, 0, 0, 1, t);
    send_beat(90, 1, 0, 1, t);
    drain();
    check_got("toggle", 0, 10, 1, 3);

    // Reset mid-frame discards the partial frame
    got_q.delete();
    send_beat(5, 0, 0, 1, t);
    send_beat(6, 0, 0, 1, t);
    do_reset();
    send_beat(7, 1, 0, 1, t);
    drain();
    check_got("rst_frame", 0, 7, 0, 1);

    // Random traffic; the second half uses rarer in_last so the length cap is exercised
    for (int i = 0; i < 3000; i++) begin
      lp = (i < 1500) ? ($urandom % 5 == 0) : ($urandom % 30 == 0);
      step($urandom % 4 != 0,
           ($urandom % 2 == 0) ? $urandom_range(0, 7) : $urandom_range(0, 255),
           lp, 1'($urandom % 2), $urandom % 3 != 0, acc);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
